// File: rtl/apb_cmd_master.sv
// APB requester: turns a valid/ready command stream into AMBA3 APB transfers on a shared bus
// of up to four slaves and returns read data / error status on a valid/ready response channel.
module apb_cmd_master #(
    parameter int unsigned P_NUM         = 4,
    parameter logic [31:0] P_ADDR_START0 = 32'h0000_0000,
    parameter logic [31:0] P_ADDR_START1 = 32'h0001_0000,
    parameter logic [31:0] P_ADDR_START2 = 32'h0002_0000,
    parameter logic [31:0] P_ADDR_START3 = 32'h0003_0000,
    parameter int unsigned P_SIZE0       = 1024,
    parameter int unsigned P_SIZE1       = 1024,
    parameter int unsigned P_SIZE2       = 1024,
    parameter int unsigned P_SIZE3       = 1024,
    parameter int unsigned P_TIMEOUT     = 256
) (
    input  logic             PCLK,
    input  logic             PRESET,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_addr,
    input  logic             req_write,
    input  logic [31:0]      req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_rdata,
    output logic             rsp_err,
    output logic [P_NUM-1:0] PSEL,
    output logic [31:0]      PADDR,
    output logic             PENABLE,
    output logic             PWRITE,
    output logic [31:0]      PWDATA,
    input  logic [31:0]      PRDATA0,
    input  logic [31:0]      PRDATA1,
    input  logic [31:0]      PRDATA2,
    input  logic [31:0]      PRDATA3,
    input  logic [P_NUM-1:0] PREADY,
    input  logic [P_NUM-1:0] PSLVERR
);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

    localparam logic [3:0][31:0] START = {P_ADDR_START3, P_ADDR_START2,
                                          P_ADDR_START1, P_ADDR_START0};
    localparam logic [3:0][32:0] SIZE  = {33'(P_SIZE3), 33'(P_SIZE2),
                                          33'(P_SIZE1), 33'(P_SIZE0)};
    localparam logic [31:0] TMO_LAST   = (P_TIMEOUT == 0) ? 32'd0 : 32'(P_TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [1:0]  sel_q, sel_d;
    logic [31:0] addr_q, addr_d;
    logic        write_q, write_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [31:0] tcnt_q, tcnt_d;

    logic        hit;
    logic [1:0]  hit_idx;
    logic [3:0]  pready_pad, pslverr_pad, psel_full;
    logic        pready_sel, pslverr_sel;
    logic [31:0] prdata_sel;

    // Scan downwards so the lowest matching window wins on overlap.
    always_comb begin
        hit     = 1'b0;
        hit_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (i < int'(P_NUM) &&
                {1'b0, req_addr} >= {1'b0, START[i]} &&
                {1'b0, req_addr} <  {1'b0, START[i]} + SIZE[i]) begin
                hit     = 1'b1;
                hit_idx = 2'(i);
            end
        end
    end

    // Only the selected slave's response signals are ever consulted.
    always_comb begin
        pready_pad  = 4'(PREADY);
        pslverr_pad = 4'(PSLVERR);
        pready_sel  = pready_pad[sel_q];
        pslverr_sel = pslverr_pad[sel_q];
        case (sel_q)
            2'd0:    prdata_sel = PRDATA0;
            2'd1:    prdata_sel = PRDATA1;
            2'd2:    prdata_sel = PRDATA2;
            default: prdata_sel = PRDATA3;
        endcase
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        tcnt_d  = tcnt_q;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    write_d = req_write;
                    wdata_d = req_wdata;
                    tcnt_d  = 32'd0;
                    if (hit) begin
                        sel_d   = hit_idx;
                        state_d = StSetup;
                    end else begin
                        rdata_d = 32'd0;
                        err_d   = 1'b1;
                        state_d = StResp;
                    end
                end
            end
            StSetup: begin
                tcnt_d  = 32'd0;
                state_d = StAccess;
            end
            StAccess: begin
                if (pready_sel) begin
                    rdata_d = (write_q || pslverr_sel) ? 32'd0 : prdata_sel;
                    err_d   = pslverr_sel;
                    state_d = StResp;
                end else if (P_TIMEOUT != 0 && tcnt_q == TMO_LAST) begin
                    rdata_d = 32'd0;
                    err_d   = 1'b1;
                    state_d = StResp;
                end else begin
                    tcnt_d = tcnt_q + 32'd1;
                end
            end
            default: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q <= StIdle;
            sel_q   <= 2'd0;
            addr_q  <= 32'd0;
            write_q <= 1'b0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
            tcnt_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            tcnt_q  <= tcnt_d;
        end
    end

    always_comb begin
        psel_full = 4'd0;
        if (state_q == StSetup || state_q == StAccess) begin
            psel_full = 4'b0001 << sel_q;
        end
    end

    assign PSEL      = psel_full[P_NUM-1:0];
    assign PENABLE   = (state_q == StAccess);
    assign PADDR     = addr_q;
    assign PWRITE    = write_q;
    assign PWDATA    = wdata_q;
    assign req_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StResp);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule
